// File: rtl/dcpu_ram_slave.sv
// Single-port 16-bit RAM responder for the dcpu master bus.
// Byte-lane strobes, optional wait states, one registered ack pulse per access.
module dcpu_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cyc,
    input  logic [1:0]  i_stb,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [15:0] i_dat,
    output logic        o_ack,
    output logic [15:0] o_dat
);

    localparam int unsigned Words = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   we_q, we_d;
    logic [1:0]             stb_q, stb_d;
    logic [15:0]            wdat_q, wdat_d;
    logic [15:0]            rdat_q, rdat_d;

    logic [15:0]            mem [Words];

    logic                   hit;
    logic                   commit;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic                   acc_we;
    logic [1:0]             acc_stb;
    logic [15:0]            acc_dat;
    logic                   unused_addr0;

    assign unused_addr0 = i_addr[0];

    assign hit = i_cyc && (i_stb != 2'b00) &&
                 (i_addr[31:ADDR_BITS+1] == BASE_ADDR[31:ADDR_BITS+1]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        stb_d   = stb_q;
        wdat_d  = wdat_q;
        // With zero wait states the access commits straight from IDLE, so the
        // live bus values are used instead of the latched copy.
        acc_idx = idx_q;
        acc_we  = we_q;
        acc_stb = stb_q;
        acc_dat = wdat_q;

        unique case (state_q)
            StIdle: begin
                acc_idx = i_addr[ADDR_BITS:1];
                acc_we  = i_we;
                acc_stb = i_stb;
                acc_dat = i_dat;
                if (hit) begin
                    idx_d  = i_addr[ADDR_BITS:1];
                    we_d   = i_we;
                    stb_d  = i_stb;
                    wdat_d = i_dat;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StWait: begin
                if (!i_cyc) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (i_reset) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end

        commit = (state_d == StAck);

        rdat_d = 16'h0000;
        if (commit && !acc_we) begin
            rdat_d[15:8] = acc_stb[1] ? mem[acc_idx][15:8] : 8'h00;
            rdat_d[7:0]  = acc_stb[0] ? mem[acc_idx][7:0]  : 8'h00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 2'b00;
            wdat_q  <= 16'h0000;
            rdat_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    // commit is already forced low under reset, so the array needs no reset term.
    always_ff @(posedge i_clk) begin
        if (commit && acc_we) begin
            if (acc_stb[1]) mem[acc_idx][15:8] <= acc_dat[15:8];
            if (acc_stb[0]) mem[acc_idx][7:0]  <= acc_dat[7:0];
        end
    end

    assign o_ack = (state_q == StAck);
    assign o_dat = rdat_q;

endmodule
